// File: rtl/relu_sram_sweep_ctrl.sv
// In-place ReLU sweep over a contiguous range of a single-port scratch SRAM.
// Read/write alternate per word; the host port passes through while idle.
module relu_sram_sweep_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   neg_cnt,
  input  logic              host_cs,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr,  w_cur_addr_nxt;
  logic [CNT_W-1:0]  r_remaining, w_remaining_nxt;
  logic [CNT_W-1:0]  r_neg_cnt,   w_neg_cnt_nxt;
  logic              w_sign;

  assign w_sign     = sram_rdata[DATA_W-1];
  assign neg_cnt    = r_neg_cnt;
  assign host_rdata = sram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_neg_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_neg_cnt   <= w_neg_cnt_nxt;
    end
  end

  // Next-state and SRAM port mux; the sweep owns the SRAM outside IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_neg_cnt_nxt   = r_neg_cnt;
    busy            = 1'b1;
    done            = 1'b0;
    host_gnt        = 1'b0;
    sram_cs         = 1'b0;
    sram_we         = 1'b0;
    sram_addr       = '0;
    sram_wdata      = '0;

    case (r_state)
      S_IDLE: begin
        busy       = 1'b0;
        host_gnt   = 1'b1;
        sram_cs    = host_cs;
        sram_we    = host_we;
        sram_addr  = host_addr;
        sram_wdata = host_wdata;
        if (start) begin
          w_cur_addr_nxt  = base_addr;
          w_remaining_nxt = len;
          w_neg_cnt_nxt   = '0;
          w_state_nxt     = (len != '0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        sram_cs     = 1'b1;
        sram_addr   = r_cur_addr;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = r_cur_addr;
        // Any word with the sign bit set (incl. -0 and negative NaN) clamps to zero.
        sram_wdata = w_sign ? '0 : sram_rdata;
        if (w_sign) begin
          w_neg_cnt_nxt = r_neg_cnt + CNT_W'(1);
        end
        w_remaining_nxt = r_remaining - CNT_W'(1);
        w_cur_addr_nxt  = r_cur_addr + ADDR_W'(1);
        w_state_nxt     = (r_remaining == CNT_W'(1)) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
